// File: rtl/ac_motor_pkg.sv
// Shared definitions for the N-phase DDS sine generator: sequencer state
// encoding, default widths and the per-channel phase offset function.
package ac_motor_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_SEQ,
        S_FLUSH
    } state_t;

    localparam int DEF_N_PHASE    = 3;
    localparam int DEF_PHASE_W    = 24;
    localparam int DEF_FREQ_W     = 9;
    localparam int DEF_FREQ_SHIFT = 8;
    localparam int DEF_LUT_AW     = 8;
    localparam int DEF_OUT_W      = 12;
    localparam int DEF_AMP_W      = 8;

    // Phase offset of channel k: floor(2^pw * k / n).
    function automatic logic [63:0] phase_offset(input int k, input int n, input int pw);
        return (64'(k) << pw) / 64'(n);
    endfunction

endpackage

// File: rtl/ac_motor_sine_lut.sv
// Quarter-wave sine magnitude ROM with registered output (one cycle latency).
// Entry i = round((2^(OUT_W-1)-1) * sin(pi/2 * (i+0.5) / 2^LUT_AW)).
module ac_motor_sine_lut #(
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 12
) (
    input  logic              clk,
    input  logic [LUT_AW-1:0] addr,
    output logic [OUT_W-2:0]  mag
);

    localparam int MAG_W = OUT_W - 1;
    localparam int DEPTH = 2 ** LUT_AW;

    function automatic logic [DEPTH*MAG_W-1:0] build_rom();
        logic [DEPTH*MAG_W-1:0] rom;
        real                    full;
        real                    x;
        rom  = '0;
        full = real'((2 ** MAG_W) - 1);
        for (int i = 0; i < DEPTH; i++) begin
            x = full * $sin(1.5707963267948966 * (real'(i) + 0.5) / real'(DEPTH));
            rom[i*MAG_W +: MAG_W] = MAG_W'($rtoi(x + 0.5));
        end
        return rom;
    endfunction

    localparam logic [DEPTH*MAG_W-1:0] ROM = build_rom();

    // NOTE: ROM output register is deliberately not reset; readers qualify it
    // with a reset pipeline valid, so a reset here would only cost area.
    always_ff @(posedge clk) begin
        mag <= ROM[int'(addr)*MAG_W +: MAG_W];
    end

endmodule

// File: rtl/ac_motor_sine_gen.sv
// N-phase DDS sine reference: phase accumulator stepped per carrier tick,
// time-multiplexed quarter-wave lookups, amplitude scaling, simultaneous update.
// Optional frequency slew limiting is enabled with `AC_MOTOR_SINE_RAMP_EN.
module ac_motor_sine_gen
    import ac_motor_pkg::*;
#(
    parameter int N_PHASE    = DEF_N_PHASE,
    parameter int PHASE_W    = DEF_PHASE_W,
    parameter int FREQ_W     = DEF_FREQ_W,
    parameter int FREQ_SHIFT = DEF_FREQ_SHIFT,
    parameter int LUT_AW     = DEF_LUT_AW,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int AMP_W      = DEF_AMP_W
`ifdef AC_MOTOR_SINE_RAMP_EN
    , parameter int RAMP_STEP = 1
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic [FREQ_W-1:0]        frequency,
    input  logic                     direction,
    input  logic [AMP_W:0]           amplitude,
    input  logic                     overrun_clr,
    output logic [N_PHASE*OUT_W-1:0] sine,
    output logic                     sine_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int CNT_W  = $clog2(N_PHASE + 3);
    localparam int PROD_W = OUT_W + AMP_W + 1;
    localparam int TOP_W  = LUT_AW + 2;
    localparam logic [AMP_W:0]     AMP_UNITY     = (AMP_W + 1)'(1) << AMP_W;
    localparam logic [CNT_W-1:0]   CNT_SEQ_END   = CNT_W'(N_PHASE);
    localparam logic [CNT_W-1:0]   CNT_FLUSH0    = CNT_W'(N_PHASE + 1);
    localparam logic [CNT_W-1:0]   CNT_FLUSH_END = CNT_W'(N_PHASE + 2);

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt;
    logic                 accept;
    logic [FREQ_W-1:0]    freq_use;
    logic [PHASE_W-1:0]   acc, inc, offset;
    logic [AMP_W:0]       amp_q;
    logic [PHASE_W-1:0]   offs [N_PHASE];

    logic                 issue_v;
    logic [TOP_W-1:0]     p_top;
    logic [LUT_AW-1:0]    lut_addr;
    logic                 v1, neg1;
    logic [CNT_W-1:0]     ch1;
    logic [OUT_W-2:0]     mag;
    logic signed [OUT_W-1:0]  lut_s;
    logic signed [AMP_W+1:0]  amp_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [OUT_W-1:0]  scaled;
    logic [N_PHASE*OUT_W-1:0] work;

    assign accept = (state == S_IDLE) && tick;
    assign busy   = (state != S_IDLE);

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (tick) state_next = S_ACC;
            S_ACC:   state_next = S_SEQ;
            S_SEQ:   if (cnt == CNT_SEQ_END) state_next = S_FLUSH;
            S_FLUSH: if (cnt == CNT_FLUSH_END) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state == S_IDLE) ? '0 : cnt + 1'b1;
        end
    end

`ifdef AC_MOTOR_SINE_RAMP_EN
    localparam logic [FREQ_W-1:0] STEP = FREQ_W'(RAMP_STEP);
    logic [FREQ_W-1:0] freq_act;

    always_comb begin
        freq_use = freq_act;
        if (frequency > freq_act)
            freq_use = (frequency - freq_act > STEP) ? freq_act + STEP : frequency;
        else if (frequency < freq_act)
            freq_use = (freq_act - frequency > STEP) ? freq_act - STEP : frequency;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       freq_act <= '0;
        else if (accept) freq_act <= freq_use;
    end
`else
    assign freq_use = frequency;
`endif

    assign inc = PHASE_W'(freq_use) << FREQ_SHIFT;

    for (genvar k = 0; k < N_PHASE; k++) begin : g_off
        assign offs[k] = PHASE_W'(phase_offset(k, N_PHASE, PHASE_W));
    end

    always_comb begin
        offset = '0;
        for (int k = 0; k < N_PHASE; k++)
            if (cnt == CNT_W'(k)) offset = offs[k];
    end

    // Channel cnt is addressed during ACC and the first N_PHASE-1 SEQ cycles.
    assign issue_v  = ((state == S_ACC) || (state == S_SEQ)) && (cnt < CNT_SEQ_END);
    assign p_top    = TOP_W'((acc + offset) >> (PHASE_W - TOP_W));
    assign lut_addr = p_top[LUT_AW] ? ~p_top[LUT_AW-1:0] : p_top[LUT_AW-1:0];

    ac_motor_sine_lut #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_lut (
        .clk  (clk),
        .addr (lut_addr),
        .mag  (mag)
    );

    assign lut_s  = neg1 ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    assign amp_s  = $signed({1'b0, amp_q});
    assign prod   = PROD_W'(lut_s) * PROD_W'(amp_s);
    assign scaled = OUT_W'(prod >>> AMP_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc        <= '0;
            amp_q      <= '0;
            overrun    <= 1'b0;
            v1         <= 1'b0;
            neg1       <= 1'b0;
            ch1        <= '0;
            work       <= '0;
            sine       <= '0;
            sine_valid <= 1'b0;
        end else begin
            if (accept) begin
                acc   <= direction ? acc - inc : acc + inc;
                amp_q <= (amplitude > AMP_UNITY) ? AMP_UNITY : amplitude;
            end
            // A new overrun takes priority over a simultaneous clear.
            if (tick && busy)     overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;

            v1   <= issue_v;
            neg1 <= p_top[LUT_AW+1];
            ch1  <= cnt;
            if (v1) work[ch1*OUT_W +: OUT_W] <= scaled;

            sine_valid <= 1'b0;
            if ((state == S_FLUSH) && (cnt == CNT_FLUSH0)) begin
                sine       <= work;
                sine_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ac_motor_sine_gen.sv
// Directed self-checking bench for ac_motor_sine_gen (default parameters);
// the ramp section is compiled only with AC_MOTOR_SINE_RAMP_EN.
module tb_ac_motor_sine_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [8:0]  frequency;
    logic        direction;
    logic [8:0]  amplitude;
    logic        overrun_clr;
    logic [35:0] sine;
    logic        sine_valid;
    logic        busy;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    int nvalid;

    ac_motor_sine_gen dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .frequency   (frequency),
        .direction   (direction),
        .amplitude   (amplitude),
        .overrun_clr (overrun_clr),
        .sine        (sine),
        .sine_valid  (sine_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic signed [11:0] ch(input int k);
        return sine[k*12 +: 12];
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one tick and return the cycle offset (T+n) at which sine_valid is seen.
    task automatic do_tick(output int latency);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        latency = 1;
        while (!sine_valid && latency < 20) begin
            @(negedge clk);
            latency++;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; frequency = '0; direction = 1'b0;
        amplitude = 9'd256; overrun_clr = 1'b0;
        idle_cycles(2);
        check("rst_busy",    busy, 0);
        check("rst_valid",   sine_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_sine",    (sine == '0), 1);
        reset = 1'b0;
        idle_cycles(2);

        // Phase values at acc=0, unity amplitude
        do_tick(lat);
        check("t2_latency", lat, 6);
        check("t2_ch0", ch(0), 6);
        check("t2_ch1", ch(1), 1772);
        check("t2_ch2", ch(2), -1772);
        check("t2_busy_last", busy, 1);
        @(negedge clk);
        check("t2_valid_pulse", sine_valid, 0);
        check("t2_busy_done", busy, 0);

        // Amplitude scaling
        amplitude = 9'd128;
        do_tick(lat);
        check("t3_half_ch0", ch(0), 3);
        check("t3_half_ch1", ch(1), 886);
        check("t3_half_ch2", ch(2), -886);
        idle_cycles(2);
        amplitude = 9'd300;
        do_tick(lat);
        check("t3_clamp_ch0", ch(0), 6);
        check("t3_clamp_ch1", ch(1), 1772);
        idle_cycles(2);
        amplitude = 9'd1;
        do_tick(lat);
        check("t3_amp1_ch0", ch(0), 0);
        check("t3_amp1_ch1", ch(1), 6);
        check("t3_amp1_ch2", ch(2), -7);
        idle_cycles(2);
        amplitude = 9'd0;
        do_tick(lat);
        check("t3_zero_ch0", ch(0), 0);
        check("t3_zero_ch1", ch(1), 0);
        check("t3_zero_ch2", ch(2), 0);
        idle_cycles(2);

        // Reverse wrap below zero
        amplitude = 9'd256; direction = 1'b1; frequency = 9'd1;
        do_tick(lat);
        check("t4_acc", dut.acc, 32'h00FF_FF00);
        check("t4_ch0", ch(0), -6);
        check("t4_ch1", ch(1), 1772);
        idle_cycles(2);

        // Overrun: second tick three cycles after the first
        direction = 1'b0; frequency = 9'd0;
        check("t5_overrun_pre", overrun, 0);
        nvalid = 0;
        tick = 1'b1;
        idle_cycles(3);
        tick = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tick = 1'b0;
            if (sine_valid) nvalid++;
        end
        check("t5_one_valid", nvalid, 1);
        check("t5_overrun_set", overrun, 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("t5_overrun_clr", overrun, 0);

        // Set beats clear in the same cycle
        tick = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        tick = 1'b0; overrun_clr = 1'b0;
        check("t5_set_wins", overrun, 1);
        idle_cycles(10);

`ifdef AC_MOTOR_SINE_RAMP_EN
        // Ramp 0 -> 10 one step per accepted tick, then constant
        frequency = 9'd10;
        for (int i = 1; i <= 12; i++) begin
            logic [23:0] before;
            before = dut.acc;
            do_tick(lat);
            check($sformatf("t6_inc%0d", i), 32'(dut.acc - before), 32'((i < 10 ? i : 10) * 256));
            idle_cycles(2);
        end
`endif

        // Reset mid-sequence clears everything at once and suppresses the valid
        tick = 1'b1;
        @(negedge clk);
        idle_cycles(1);
        @(negedge clk);
        check("t1_overrun_pre", overrun, 1);
        tick = 1'b0;
        reset = 1'b1;
        #1;
        check("t1_busy",    busy, 0);
        check("t1_sine",    (sine == '0), 1);
        check("t1_overrun", overrun, 0);
        check("t1_valid",   sine_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sine_valid) nvalid++;
        end
        check("t1_no_valid", nvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
